calc_scrolling_display: RTL
===========================

Name: calc_scrolling_display

Overview:
Parametrised successor to the calculator's four-digit seven-segment display driver. Multiplexes an N-digit common-anode display and selects among a blank screen, the 16-bit switch input, the operation code, or an answer of arbitrary width. For answers wider than the display, a debounced up/down button pair scrolls a nibble-granular window across the answer. A matching LED slice is driven alongside. Sits between the stage selector (mode strobes) and the board's seg/an/led pins.

Parameters:
ANSWER_WIDTH, 32, answer width in bits; multiple of 4, >= 4*NUM_DIGITS
NUM_DIGITS, 4, number of multiplexed digits; >= 2
REFRESH_DIV, 100000, clock cycles each digit stays lit
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must stay stable before it is accepted
LED_WIDTH, 8, width of the LED answer visualiser; <= 4*NUM_DIGITS

Ports:
IN_clk  input  1  system clock; all logic on the rising edge
IN_reset_n  input  1  synchronous reset, active-low
IN_switches  input  16  raw switch value for input mode
IN_operation_code  input  3  operation selector for operation mode
IN_answer  input  ANSWER_WIDTH  calculator result, live (not sampled)
IN_show_16bit_input  input  1  mode strobe: show switches
IN_show_operation  input  1  mode strobe: show op code
IN_show_answer  input  1  mode strobe: show answer window
IN_up_button  input  1  raw, asynchronous; scroll toward MSB
IN_down_button  input  1  raw, asynchronous; scroll toward LSB
IN_center_button  input  1  raw, asynchronous; return window to offset 0
OUT_Led_Visualizer_answer  output  LED_WIDTH  answer slice at current window
OUT_cathode  output  7  active-low segments {g,f,e,d,c,b,a}
OUT_anode  output  NUM_DIGITS  active-low one-hot digit enable; digit 0 is rightmost

Behaviour:
- Reset (IN_reset_n=0 at a clock edge):
  - OUT_anode all 1, OUT_cathode 7'h7F, OUT_Led_Visualizer_answer 0.
  - Window offset 0, scan index 0, refresh counter 0.
  - All debouncer state cleared to "released".
  - Reset asserted mid-scan or mid-debounce aborts the operation immediately.
- Mode priority:
  - Answer > operation > input > blank, selected from the strobes each cycle.
  - Blank mode: all digits show 7'h7F with the scan still running.
- Buttons:
  - Each button goes through a 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
  - A press event is a one-cycle pulse on the debounced 0->1 edge. Release generates nothing. Holding produces no repeat.
- Window offset:
  - Range 0..MAX_OFF, in nibbles, where MAX_OFF = ANSWER_WIDTH/4 - NUM_DIGITS.
  - Up event: offset+1, saturating at MAX_OFF. Down event: offset-1, saturating at 0.
  - Up and down events in the same cycle: no change.
  - Center event: offset 0, and it takes precedence over up/down in the same cycle.
  - Events are ignored unless answer mode is active.
  - Offset is forced to 0 on any cycle where answer mode is not active, so re-entering answer mode always starts at the LSBs.
- Digit contents:
  - Answer mode: digit i shows hex nibble IN_answer[4*(offset+i)+3 : 4*(offset+i)].
  - Input mode: digit i shows switch nibble i for i<4; digits >= 4 are blank.
  - Operation mode: digit 0 shows the op code as hex 0-7; digit 1 shows the minus glyph (7'h3F, g only lit); other digits are blank.
  - Hex glyphs are the standard 0-F (including lowercase b/d), active-low.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index advances modulo NUM_DIGITS.
  - OUT_anode and OUT_cathode are registered and update together on the edge after the scan index changes, so one digit is lit at a time with no ghosting.
  - Content changes (mode, offset, answer) appear at the next digit refresh.
- LEDs:
  - Registered, 1-cycle latency.
  - Answer mode: IN_answer[4*offset+LED_WIDTH-1 : 4*offset]. Otherwise 0.

Test Plan:
(Bench uses REFRESH_DIV=4, DEBOUNCE_CYCLES=3; all other parameters default.)
- Reset, then answer mode with IN_answer=32'hF331CC0F -> digits 0..3 show F,0,C,C (cathodes 7'h0E,7'h40,7'h46,7'h46); anode cycles 1110,1101,1011,0111 every 4 clocks; LEDs 8'h0F.
- Four clean up presses -> offset 4; digits show 1,3,3,F; LEDs 8'h31. A fifth press -> no change (saturation).
- Up bouncing 1-0-1 within 2 cycles, then held 10 cycles -> exactly one offset increment. Up and down pressed in the same cycle -> offset unchanged.
- At offset 3: press center -> offset 0. Center together with up -> offset 0.
- Drop answer mode, assert operation mode with op=3'd5 -> digit0 7'h12, digit1 7'h3F, others 7'h7F, LEDs 0. Re-enter answer mode -> offset 0.
- Reset asserted mid-scan at offset 2 -> next edge anodes all 1, cathode 7'h7F, LEDs 0; after release the window is at offset 0.

Source files
------------

// File: rtl/calc_scrolling_display.sv
// N-digit common-anode seven-segment driver with a scrollable answer window,
// debounced scroll buttons and an LED slice of the answer at the same window.

module calc_scrolling_display_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronised samples that disagree with level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module calc_scrolling_display #(
    parameter int ANSWER_WIDTH    = 32,
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LED_WIDTH       = 8
) (
    input  logic                    IN_clk,
    input  logic                    IN_reset_n,
    input  logic [15:0]             IN_switches,
    input  logic [2:0]              IN_operation_code,
    input  logic [ANSWER_WIDTH-1:0] IN_answer,
    input  logic                    IN_show_16bit_input,
    input  logic                    IN_show_operation,
    input  logic                    IN_show_answer,
    input  logic                    IN_up_button,
    input  logic                    IN_down_button,
    input  logic                    IN_center_button,
    output logic [LED_WIDTH-1:0]    OUT_Led_Visualizer_answer,
    output logic [6:0]              OUT_cathode,
    output logic [NUM_DIGITS-1:0]   OUT_anode
);
    localparam int MAX_OFF = ANSWER_WIDTH / 4 - NUM_DIGITS;
    localparam int OFF_W   = (MAX_OFF > 0) ? $clog2(MAX_OFF + 1) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int AW_W    = $clog2(ANSWER_WIDTH);
    localparam int UP = 0, DN = 1, CTR = 2;

    logic [2:0]           raw_btn;
    logic [2:0]           press;
    logic [OFF_W-1:0]     off;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     cnt;
    logic [AW_W-1:0]      dig_base;
    logic [AW_W-1:0]      led_base;
    logic [3:0]           sw_base;
    logic [3:0]           ans_nib;
    logic [3:0]           sw_nib;
    logic [6:0]           seg;
    logic [LED_WIDTH-1:0] led_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign raw_btn = {IN_center_button, IN_down_button, IN_up_button};

    for (genvar b = 0; b < 3; b++) begin : g_btn
        calc_scrolling_display_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (IN_clk),
            .reset_n(IN_reset_n),
            .raw    (raw_btn[b]),
            .press  (press[b])
        );
    end

    // Leaving answer mode parks the window at the LSBs
    always_ff @(posedge IN_clk) begin
        if (!IN_reset_n || !IN_show_answer || press[CTR]) begin
            off <= '0;
        end else if (press[UP] && !press[DN]) begin
            if (off != OFF_W'(MAX_OFF)) off <= off + 1'b1;
        end else if (press[DN] && !press[UP]) begin
            if (off != '0) off <= off - 1'b1;
        end
    end

    always_comb begin
        dig_base = AW_W'(4 * (int'(off) + int'(idx)));
        led_base = AW_W'(4 * int'(off));
        sw_base  = 4'(4 * int'(idx));
        for (int j = 0; j < 4; j++) begin
            ans_nib[j] = IN_answer[dig_base + AW_W'(j)];
            sw_nib[j]  = IN_switches[sw_base + 4'(j)];
        end
        for (int b = 0; b < LED_WIDTH; b++) begin
            led_next[b] = IN_answer[led_base + AW_W'(b)];
        end
        seg = 7'h7F;
        if (IN_show_answer) begin
            seg = hex7(ans_nib);
        end else if (IN_show_operation) begin
            if (idx == '0)             seg = hex7({1'b0, IN_operation_code});
            else if (idx == IDX_W'(1)) seg = 7'h3F;
        end else if (IN_show_16bit_input) begin
            if (int'(idx) < 4) seg = hex7(sw_nib);
        end
    end

    // Anode and cathode load together once per digit slot, on the first cycle
    // of the slot, so the segment pattern never straddles two digits.
    always_ff @(posedge IN_clk) begin
        if (!IN_reset_n) begin
            cnt                       <= '0;
            idx                       <= '0;
            OUT_anode                 <= '1;
            OUT_cathode               <= 7'h7F;
            OUT_Led_Visualizer_answer <= '0;
        end else begin
            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == '0) begin
                OUT_anode   <= ~(NUM_DIGITS'(1) << idx);
                OUT_cathode <= seg;
            end
            OUT_Led_Visualizer_answer <= IN_show_answer ? led_next : '0;
        end
    end
endmodule
